// File: rtl/uno_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : uno_seq_if
//  Purpose  : Bundles the uno_seq command, coefficient-load, uno-drive and
//             result signals. clk and rst_n are not part of the bundle.
//  Modports : master - environment side: issues commands and coefficient
//                      writes, returns mac_res, consumes results
//             slave  - sequencer side (uno_seq)
//  Signals  : cmd_valid/cmd_ready/cmd_op/cmd_x/cmd_y/cmd_z/cmd_acc
//             coef_we/coef_op/coef_addr/coef_data
//             uno_op/uno_x/uno_y/uno_z/uno_coeff/uno_first/uno_last/uno_acc_en
//             mac_res, res_valid/res_ready/res_data
//  Revision : 1.0 - initial release
// ============================================================================
interface uno_seq_if #(
  parameter int MAC_BW = 12
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [MAC_BW-1:0]     cmd_x;
  logic [MAC_BW-1:0]     cmd_y;
  logic [2*MAC_BW-1:0]   cmd_z;
  logic                  cmd_acc;

  logic                  coef_we;
  logic [1:0]            coef_op;
  logic [2:0]            coef_addr;
  logic [MAC_BW-1:0]     coef_data;

  logic [1:0]            uno_op;
  logic [MAC_BW-1:0]     uno_x;
  logic [MAC_BW-1:0]     uno_y;
  logic [2*MAC_BW-1:0]   uno_z;
  logic [MAC_BW-1:0]     uno_coeff;
  logic                  uno_first;
  logic                  uno_last;
  logic                  uno_acc_en;

  logic [2*MAC_BW-1:0]   mac_res;
  logic                  res_valid;
  logic                  res_ready;
  logic [2*MAC_BW-1:0]   res_data;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_z, cmd_acc,
    output coef_we, coef_op, coef_addr, coef_data,
    output mac_res, res_ready,
    input  cmd_ready, res_valid, res_data,
    input  uno_op, uno_x, uno_y, uno_z, uno_coeff, uno_first, uno_last, uno_acc_en
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_z, cmd_acc,
    input  coef_we, coef_op, coef_addr, coef_data,
    input  mac_res, res_ready,
    output cmd_ready, res_valid, res_data,
    output uno_op, uno_x, uno_y, uno_z, uno_coeff, uno_first, uno_last, uno_acc_en
  );
endinterface
`default_nettype wire

// File: rtl/uno_seq.sv
`default_nettype none
// ============================================================================
//  Module   : uno_seq
//  Purpose  : Sequences one command onto the uno datapath. A MAC command is a
//             single issue cycle; div/exp/log commands walk a TERMS-entry
//             Horner coefficient table (highest index first) followed by one
//             scale step. One wait cycle later the registered uno result is
//             captured and held until the consumer takes it.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset
//             bus   - uno_seq_if.slave (command, coefficient load,
//                     uno drive, result handshake)
//  Params   : MAC_BW - operand width, TERMS - Horner steps per non-MAC op (2..8)
//  Revision : 1.0 - initial release
// ============================================================================
module uno_seq #(
  parameter int MAC_BW = 12,
  parameter int TERMS  = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  uno_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            k, k_nxt;

  // latched command
  logic [1:0]            op_q;
  logic [MAC_BW-1:0]     x_q;
  logic [MAC_BW-1:0]     y_q;
  logic [2*MAC_BW-1:0]   z_q;
  logic                  acc_q;

  // coefficient tables: index 0..2 holds ops 01..11
  logic [MAC_BW-1:0]     coef [3][TERMS];
  logic [MAC_BW-1:0]     coef_rd;
  logic [3:0]            rd_idx;

  logic [2*MAC_BW-1:0]   res_q;

  logic                  accept;
  logic                  coef_wr;

  assign accept  = (state == S_IDLE) && bus.cmd_valid;
  assign coef_wr = (state == S_IDLE) && bus.coef_we;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      k     <= 4'd0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_RUN;
          k_nxt     = 4'd0;
        end
      end
      S_RUN: begin
        // MAC issues once; Horner ops finish after the scale step k == TERMS
        if (op_q == 2'd0 || k == 4'(TERMS)) begin
          state_nxt = S_WAIT;
          k_nxt     = 4'd0;
        end else begin
          k_nxt = k + 4'd1;
        end
      end
      S_WAIT:  state_nxt = S_OUT;
      S_OUT: begin
        if (bus.res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Command latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 2'd0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      acc_q <= 1'b0;
    end else if (accept) begin
      op_q  <= bus.cmd_op;
      x_q   <= bus.cmd_x;
      y_q   <= bus.cmd_y;
      z_q   <= bus.cmd_z;
      acc_q <= bus.cmd_acc;
    end
  end

  // --------------------------------------------------------------------------
  // Coefficient tables. Only entries that exist are matched, so op 00 and
  // addresses >= TERMS fall through without a write.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < 3; t++)
        for (int i = 0; i < TERMS; i++)
          coef[t][i] <= '0;
    end else if (coef_wr) begin
      for (int t = 0; t < 3; t++)
        for (int i = 0; i < TERMS; i++)
          if (bus.coef_op == 2'(t + 1) && bus.coef_addr == 3'(i))
            coef[t][i] <= bus.coef_data;
    end
  end

  // Horner order: step k uses entry TERMS-1-k. At the scale step the index
  // wraps to an out-of-range value, so nothing matches and 0 is read.
  always_comb begin
    coef_rd = '0;
    rd_idx  = 4'(TERMS - 1) - k;
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < TERMS; i++)
        if (op_q == 2'(t + 1) && rd_idx == 4'(i))
          coef_rd = coef[t][i];
  end

  // --------------------------------------------------------------------------
  // Result capture: mac_res is valid at the end of the single wait cycle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (state == S_WAIT) begin
      res_q <= bus.mac_res;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.uno_op     = 2'd0;
    bus.uno_x      = '0;
    bus.uno_y      = '0;
    bus.uno_z      = '0;
    bus.uno_coeff  = '0;
    bus.uno_first  = 1'b0;
    bus.uno_last   = 1'b0;
    bus.uno_acc_en = 1'b0;
    if (state == S_RUN) begin
      bus.uno_op = op_q;
      bus.uno_x  = x_q;
      bus.uno_y  = y_q;
      bus.uno_z  = z_q;
      if (op_q == 2'd0) begin
        bus.uno_acc_en = acc_q;
      end else begin
        bus.uno_first = (k == 4'd0);
        bus.uno_last  = (k == 4'(TERMS));
        bus.uno_coeff = coef_rd;
      end
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.res_valid = (state == S_OUT);
  assign bus.res_data  = res_q;

endmodule
`default_nettype wire

// File: tb/tb_uno_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uno_seq
//  Purpose  : Self-checking bench for uno_seq (MAC_BW = 12, TERMS = 4).
//             A transaction-level model turns each accepted command into the
//             list of cycles it must produce; a compare loop checks every
//             cycle against it, and directed steps pin literal values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uno_seq;
  localparam int MAC_BW = 12;
  localparam int TERMS  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uno_seq_if #(.MAC_BW(MAC_BW)) bus();

  uno_seq #(.MAC_BW(MAC_BW), .TERMS(TERMS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [1:0]  op;
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] z;
    logic [11:0] coeff;
    logic        first;
    logic        last;
    logic        acc;
    logic        acc_care;
    logic        is_wait;
  } step_t;

  step_t       sched[$];
  logic        m_out = 1'b0;
  logic [23:0] m_res = '0;
  logic [11:0] m_coef [4][8];

  always @(posedge clk or negedge rst_n) begin : model
    step_t st;
    if (!rst_n) begin
      sched.delete();
      m_out = 1'b0;
      m_res = '0;
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 8; b++)
          m_coef[a][b] = '0;
    end else if (sched.size() == 0 && !m_out) begin
      if (bus.coef_we && bus.coef_op != 2'd0 && int'(bus.coef_addr) < TERMS)
        m_coef[bus.coef_op][bus.coef_addr] = bus.coef_data;
      if (bus.cmd_valid) begin
        if (bus.cmd_op == 2'd0) begin
          st = '0;
          st.x = bus.cmd_x; st.y = bus.cmd_y; st.z = bus.cmd_z;
          st.acc = bus.cmd_acc; st.acc_care = 1'b1;
          sched.push_back(st);
        end else begin
          for (int s = 0; s <= TERMS; s++) begin
            st = '0;
            st.op = bus.cmd_op;
            st.x = bus.cmd_x; st.y = bus.cmd_y; st.z = bus.cmd_z;
            st.coeff = (s < TERMS) ? m_coef[bus.cmd_op][TERMS-1-s] : 12'h000;
            st.first = (s == 0);
            st.last  = (s == TERMS);
            sched.push_back(st);
          end
        end
        st = '0;
        st.is_wait = 1'b1;
        st.acc_care = 1'b1;
        sched.push_back(st);
      end
    end else if (sched.size() != 0) begin
      st = sched.pop_front();
      if (st.is_wait) begin
        m_res = bus.mac_res;
        m_out = 1'b1;
      end
    end else if (bus.res_ready) begin
      m_out = 1'b0;
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_loop();
    step_t       st;
    logic [66:0] act, exp;
    logic        idle;
    forever begin
      @(negedge clk);
      idle = (sched.size() == 0) && !m_out;
      st = (sched.size() != 0) ? sched[0] : '0;
      if (sched.size() == 0) st.acc_care = 1'b1;
      exp = {idle, m_out, st.op, st.x, st.y, st.z, st.coeff, st.first, st.last, st.acc};
      act = {bus.cmd_ready, bus.res_valid, bus.uno_op, bus.uno_x, bus.uno_y, bus.uno_z,
             bus.uno_coeff, bus.uno_first, bus.uno_last, bus.uno_acc_en};
      if (!st.acc_care) act[0] = exp[0];
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL cycle_outputs t=%0t: got 0x%0h want 0x%0h", $time, act, exp);
      end
      if (m_out) begin
        total++;
        if (bus.res_data !== m_res) begin
          bad++;
          $display("FAIL cycle_res_data t=%0t: got 0x%0h want 0x%0h", $time, bus.res_data, m_res);
        end
      end
    end
  endtask

  task automatic mac_res_drive();
    forever begin
      @(posedge clk);
      #2;
      bus.mac_res = bus.mac_res * 24'd5 + 24'h0003A7;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [11:0] x, input logic [11:0] y,
                      input logic [23:0] z, input logic acc);
    bus.cmd_op = op; bus.cmd_x = x; bus.cmd_y = y; bus.cmd_z = z; bus.cmd_acc = acc;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic coef_w(input logic [1:0] op, input logic [2:0] addr, input logic [11:0] d);
    bus.coef_op = op; bus.coef_addr = addr; bus.coef_data = d;
    bus.coef_we = 1'b1;
    tick();
    bus.coef_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 40) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.cmd_ready), 32'd1);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [11:0] exp_tab [5];
  logic [23:0] saved;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_x = '0; bus.cmd_y = '0;
    bus.cmd_z = '0; bus.cmd_acc = 1'b0;
    bus.coef_we = 1'b0; bus.coef_op = 2'd0; bus.coef_addr = 3'd0; bus.coef_data = '0;
    bus.mac_res = 24'h012345;
    bus.res_ready = 1'b1;
    exp_tab[0] = 12'h00B; exp_tab[1] = 12'h02B; exp_tab[2] = 12'h080;
    exp_tab[3] = 12'h100; exp_tab[4] = 12'h000;

    fork
      compare_loop();
      mac_res_drive();
    join_none

    // reset state
    tick(); tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data",  32'(bus.res_data),  32'd0);
    chk("rst_uno_coeff", 32'(bus.uno_coeff), 32'd0);

    // MAC command offered while reset held: must not be taken
    bus.cmd_op = 2'd0; bus.cmd_x = 12'd3; bus.cmd_y = 12'd5; bus.cmd_z = 24'd7;
    bus.cmd_acc = 1'b1; bus.cmd_valid = 1'b1;
    tick();
    chk("rst_no_accept", 32'(bus.cmd_ready), 32'd1);
    rst_n = 1'b1;
    tick();                      // accept edge
    bus.cmd_valid = 1'b0;
    chk("mac_acc_en", 32'(bus.uno_acc_en), 32'd1);
    chk("mac_x",      32'(bus.uno_x),      32'd3);
    chk("mac_z",      32'(bus.uno_z),      32'd7);
    chk("mac_first",  32'(bus.uno_first),  32'd0);
    chk("mac_last",   32'(bus.uno_last),   32'd0);
    tick();
    chk("mac_wait_valid", 32'(bus.res_valid), 32'd0);
    tick();
    chk("mac_res_valid_lat2", 32'(bus.res_valid), 32'd1);
    tick();
    chk("mac_back_idle", 32'(bus.cmd_ready), 32'd1);

    // coefficient tables, plus writes that must be dropped
    coef_w(2'd2, 3'd0, 12'h100); coef_w(2'd2, 3'd1, 12'h080);
    coef_w(2'd2, 3'd2, 12'h02B); coef_w(2'd2, 3'd3, 12'h00B);
    coef_w(2'd3, 3'd0, 12'h011); coef_w(2'd3, 3'd1, 12'h022);
    coef_w(2'd3, 3'd2, 12'h033); coef_w(2'd3, 3'd3, 12'h044);
    coef_w(2'd1, 3'd0, 12'h001); coef_w(2'd1, 3'd1, 12'h002);
    coef_w(2'd1, 3'd2, 12'h003); coef_w(2'd1, 3'd3, 12'h004);
    coef_w(2'd3, 3'd4, 12'h777);
    coef_w(2'd0, 3'd0, 12'h666);

    // exp command: coefficient walk, result capture, held output
    bus.res_ready = 1'b0;
    send(2'd2, 12'h180, 12'h000, 24'h000000, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("exp_coeff", 32'(bus.uno_coeff), 32'(exp_tab[c]));
      chk("exp_first", 32'(bus.uno_first), (c == 0) ? 32'd1 : 32'd0);
      chk("exp_last",  32'(bus.uno_last),  (c == 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("exp_wait_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    saved = bus.mac_res;
    tick();
    chk("exp_res_valid", 32'(bus.res_valid), 32'd1);
    chk("exp_res_data",  32'(bus.res_data),  32'(saved));

    // back-pressure: result held, new command ignored
    bus.cmd_op = 2'd3; bus.cmd_x = 12'hABC; bus.cmd_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_data",  32'(bus.res_data),  32'(saved));
      chk("hold_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    chk("release_idle",  32'(bus.cmd_ready), 32'd1);
    chk("release_valid", 32'(bus.res_valid), 32'd0);

    // log command with a coefficient write attempted during RUN
    send(2'd3, 12'h010, 12'h020, 24'h000030, 1'b0);
    bus.coef_op = 2'd3; bus.coef_addr = 3'd2; bus.coef_data = 12'h0AA; bus.coef_we = 1'b1;
    tick();
    bus.coef_we = 1'b0;
    chk("log_k1", 32'(bus.uno_coeff), 32'h033);
    wait_idle("log_done");
    send(2'd3, 12'h011, 12'h021, 24'h000031, 1'b0);
    chk("log_k0", 32'(bus.uno_coeff), 32'h044);
    tick();
    chk("log_readback_k1", 32'(bus.uno_coeff), 32'h033);
    wait_idle("log2_done");

    // coefficient write on the same edge as a div accept
    bus.coef_op = 2'd1; bus.coef_addr = 3'd0; bus.coef_data = 12'h055; bus.coef_we = 1'b1;
    send(2'd1, 12'h007, 12'h009, 24'h000001, 1'b1);
    bus.coef_we = 1'b0;
    chk("div_k0", 32'(bus.uno_coeff), 32'h004);
    tick(); tick(); tick();
    chk("div_k3_new", 32'(bus.uno_coeff), 32'h055);
    wait_idle("div_done");

    // asynchronous reset in the middle of a div operation
    send(2'd1, 12'h00F, 12'h00E, 24'h00000D, 1'b0);
    tick(); tick();
    chk("div_k2", 32'(bus.uno_coeff), 32'h002);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("arst_coeff", 32'(bus.uno_coeff), 32'd0);
    chk("arst_x",     32'(bus.uno_x),     32'd0);
    chk("arst_valid", 32'(bus.res_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    send(2'd2, 12'h055, 12'h000, 24'h000000, 1'b0);
    chk("post_rst_first", 32'(bus.uno_first), 32'd1);
    chk("post_rst_coeff", 32'(bus.uno_coeff), 32'd0);
    tick();
    chk("post_rst_k1_first", 32'(bus.uno_first), 32'd0);
    wait_idle("post_rst_done");
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
